// File: rtl/rx_word_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rx_word_ctrl
// Purpose  : Receive-side word framer feeding the 128-bit input shift
//            register. Accepts words over valid/ready, drives the shift
//            register's data/shift inputs, and presents block_valid once a
//            full block has been shifted in, holding it until acknowledged.
//            Supports flushing a partial block and a sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module rx_word_ctrl #(
    parameter int WORDS_PER_BLOCK = 4,
    parameter int WORD_W          = 32
) (
    input  logic                                     clk,
    input  logic                                     n_rst,   // active-high, synchronous
    input  logic [WORD_W-1:0]                        word_in,
    input  logic                                     word_valid,
    output logic                                     word_ready,
    output logic [WORD_W-1:0]                        sr_data,
    output logic                                     sr_shift,
    output logic                                     block_valid,
    input  logic                                     block_ack,
    input  logic                                     flush,
    output logic [$clog2(WORDS_PER_BLOCK+1)-1:0]     word_cnt,
    output logic                                     ovf
);

    localparam int CNT_W = $clog2(WORDS_PER_BLOCK + 1);

    // FILL: collecting words; LAST: final word's shift pending; FULL: block presented
    localparam logic [1:0] c_FILL = 2'd0;
    localparam logic [1:0] c_LAST = 2'd1;
    localparam logic [1:0] c_FULL = 2'd2;

    localparam logic [CNT_W-1:0] c_LAST_IDX = CNT_W'(WORDS_PER_BLOCK - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic [1:0]        state_q,       state_d;
    logic [CNT_W-1:0]  word_cnt_q,    word_cnt_d;
    logic [WORD_W-1:0] sr_data_q,     sr_data_d;
    logic              sr_shift_q,    sr_shift_d;
    logic              block_valid_q, block_valid_d;
    logic              ovf_q,         ovf_d;
    logic              w_ready;
    logic              w_accept;

    // Ready only while filling; reset and flush both block acceptance immediately
    always_comb begin
        w_ready  = (state_q == c_FILL) & ~n_rst & ~flush;
        w_accept = word_valid & w_ready;
    end

    // Next-state logic: flush overrides accept and ack
    always_comb begin
        state_d       = state_q;
        word_cnt_d    = word_cnt_q;
        sr_data_d     = sr_data_q;
        sr_shift_d    = 1'b0;
        block_valid_d = block_valid_q;
        ovf_d         = ovf_q;

        if (flush) begin
            // Shift register contents are left alone; the next full block
            // pushes any stale words out. sr_data also keeps its value.
            state_d       = c_FILL;
            word_cnt_d    = '0;
            block_valid_d = 1'b0;
        end else begin
            case (state_q)
                c_FILL: begin
                    if (w_accept) begin
                        sr_data_d  = word_in;
                        sr_shift_d = 1'b1;
                        word_cnt_d = word_cnt_q + c_CNT_ONE;
                        if (word_cnt_q == c_LAST_IDX) begin
                            state_d = c_LAST;
                        end
                    end
                end
                c_LAST: begin
                    // The shift register absorbs the last word on this edge
                    state_d       = c_FULL;
                    block_valid_d = 1'b1;
                end
                c_FULL: begin
                    if (word_valid) begin
                        ovf_d = 1'b1;
                    end
                    if (block_ack) begin
                        state_d       = c_FILL;
                        block_valid_d = 1'b0;
                        word_cnt_d    = '0;
                    end
                end
                default: begin
                    state_d       = c_FILL;
                    word_cnt_d    = '0;
                    block_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q       <= c_FILL;
            word_cnt_q    <= '0;
            sr_data_q     <= '0;
            sr_shift_q    <= 1'b0;
            block_valid_q <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_cnt_q    <= word_cnt_d;
            sr_data_q     <= sr_data_d;
            sr_shift_q    <= sr_shift_d;
            block_valid_q <= block_valid_d;
            ovf_q         <= ovf_d;
        end
    end

    assign word_ready  = w_ready;
    assign sr_data     = sr_data_q;
    assign sr_shift    = sr_shift_q;
    assign block_valid = block_valid_q;
    assign word_cnt    = word_cnt_q;
    assign ovf         = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_word_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_word_ctrl
// Purpose  : Self-checking bench for rx_word_ctrl. A word-count level model
//            predicts accepts, shifts and block completion; completed blocks
//            go into a queue that a separate monitor compares against a
//            behavioural model of the downstream 128-bit shift register.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_word_ctrl;

    localparam int WPB   = 4;
    localparam int WW    = 32;
    localparam int CNT_W = $clog2(WPB + 1);
    localparam int BLK_W = WPB * WW;

    logic             clk = 1'b0;
    logic             n_rst;
    logic [WW-1:0]    word_in;
    logic             word_valid;
    logic             word_ready;
    logic [WW-1:0]    sr_data;
    logic             sr_shift;
    logic             block_valid;
    logic             block_ack;
    logic             flush;
    logic [CNT_W-1:0] word_cnt;
    logic             ovf;

    rx_word_ctrl #(.WORDS_PER_BLOCK(WPB), .WORD_W(WW)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .sr_data    (sr_data),
        .sr_shift   (sr_shift),
        .block_valid(block_valid),
        .block_ack  (block_ack),
        .flush      (flush),
        .word_cnt   (word_cnt),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    // Downstream shift register: first word ends up in the MS word
    logic [BLK_W-1:0] sr_model = '0;
    always @(posedge clk) begin
        if (sr_shift === 1'b1) sr_model <= {sr_model[BLK_W-WW-1:0], sr_data};
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: words in current block, block presented, sticky overflow
    int               n_m      = 0;
    bit               bv_m     = 0;
    bit               ovf_m    = 0;
    bit               sh_m     = 0;
    bit               acc_m    = 0;
    logic [WW-1:0]    data_m   = '0;
    logic [WW-1:0]    cur_words[$];
    logic [BLK_W-1:0] exp_q[$];
    int               blocks_m = 0;

    function automatic bit exp_ready();
        return !n_rst && !flush && !bv_m && (n_m < WPB);
    endfunction

    task automatic model_edge();
        logic [BLK_W-1:0] blk;
        acc_m = 0;
        sh_m  = 0;
        if (n_rst) begin
            n_m = 0; bv_m = 0; ovf_m = 0; data_m = '0;
            cur_words.delete();
        end else if (flush) begin
            n_m = 0; bv_m = 0;
            cur_words.delete();
        end else if (bv_m) begin
            if (word_valid) ovf_m = 1;
            if (block_ack) begin bv_m = 0; n_m = 0; end
        end else if (n_m == WPB) begin
            bv_m = 1;
            blk  = '0;
            foreach (cur_words[i]) blk = (blk << WW) | BLK_W'(cur_words[i]);
            exp_q.push_back(blk);
            cur_words.delete();
            blocks_m++;
        end else if (word_valid) begin
            acc_m  = 1;
            sh_m   = 1;
            data_m = word_in;
            cur_words.push_back(word_in);
            n_m++;
        end
    endtask

    // One cycle: apply inputs, check ready, advance model, check registered outputs
    task automatic drive(input logic r, input logic v, input logic [WW-1:0] w,
                         input logic a, input logic f);
        n_rst = r; word_valid = v; word_in = w; block_ack = a; flush = f;
        #1;
        chk("word_ready", BLK_W'(word_ready), BLK_W'(exp_ready()));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("sr_shift",    BLK_W'(sr_shift),    BLK_W'(sh_m));
        chk("block_valid", BLK_W'(block_valid), BLK_W'(bv_m));
        chk("word_cnt",    BLK_W'(word_cnt),    BLK_W'(n_m));
        chk("ovf",         BLK_W'(ovf),         BLK_W'(ovf_m));
        chk("sr_data",     BLK_W'(sr_data),     BLK_W'(data_m));
    endtask

    task automatic send_word(input logic [WW-1:0] w);
        int k = 0;
        do begin
            drive(1'b0, 1'b1, w, 1'b0, 1'b0);
            k++;
        end while (!acc_m && k < 100);
        if (!acc_m) begin
            checks++; errors++;
            $display("FAIL send_word_timeout: word %0h not taken after %0d cycles", w, k);
        end
    endtask

    task automatic idle(input int cycles, input logic a);
        repeat (cycles) drive(1'b0, 1'b0, '0, a, 1'b0);
    endtask

    // Monitor: compare presented block with the shift register on each rise
    int dut_shifts = 0;
    bit bv_prev    = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (block_valid === 1'b1 && !bv_prev) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL block_unexpected: got %0h expected no block", sr_model);
                end else begin
                    chk("block_data", sr_model, exp_q.pop_front());
                end
            end
            bv_prev = (block_valid === 1'b1);
            if (sr_shift === 1'b1) dut_shifts++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        int blk_start;
        int sh_start;
        int cyc;
        bit v;

        // Reset while a word is offered
        repeat (3) drive(1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        idle(1, 1'b0);

        // Back-to-back block
        send_word(32'h00112233);
        send_word(32'h44556677);
        send_word(32'h8899AABB);
        send_word(32'hCCDDEEFF);

        // Hold ack low with a word offered: overflow, ready stays low
        repeat (10) drive(1'b0, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b0);
        send_word(32'hA5A5A5A5);
        send_word(32'h01020304);
        send_word(32'h05060708);
        send_word(32'h090A0B0C);
        idle(2, 1'b0);
        idle(1, 1'b1);

        // Flush after two words, flush wins over a simultaneous offer
        send_word(32'h11110000);
        send_word(32'h22220000);
        drive(1'b0, 1'b1, 32'h33330000, 1'b0, 1'b1);
        send_word(32'hC0000001);
        send_word(32'hC0000002);
        send_word(32'hC0000003);
        send_word(32'hC0000004);
        idle(2, 1'b0);
        idle(1, 1'b1);

        // Flush in the LAST cycle cancels the block
        send_word(32'hD0000001);
        send_word(32'hD0000002);
        send_word(32'hD0000003);
        send_word(32'hD0000004);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
        idle(4, 1'b0);

        // Clear ovf before random traffic
        repeat (2) drive(1'b1, 1'b0, '0, 1'b0, 1'b0);

        // Random gaps and ack delays; first half never offers in FULL
        blk_start = blocks_m;
        sh_start  = dut_shifts;
        cyc       = 0;
        word_in   = $urandom;
        while ((blocks_m - blk_start) < 200 && cyc < 20000) begin
            logic [WW-1:0] w;
            w = word_in;
            if (acc_m) w = $urandom;
            v = ($urandom_range(0, 3) != 0);
            if (bv_m && (blocks_m - blk_start) <= 100) v = 0;
            drive(1'b0, v, w,
                  bv_m ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0),
                  1'b0);
            cyc++;
        end
        chk("random_blocks", BLK_W'(blocks_m - blk_start), BLK_W'(200));
        chk("random_shifts", BLK_W'(dut_shifts - sh_start), BLK_W'(4 * (blocks_m - blk_start)));

        idle(1, 1'b1);
        idle(3, 1'b0);
        chk("scoreboard_drained", BLK_W'(exp_q.size()), BLK_W'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
